// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//
// Pointer, flag and handshake controller for a synchronous FIFO wrapped around
// a dual-port RAM with a registered read port (one-cycle read latency, no
// write-before-read guarantee). The data path runs straight to the RAM; this
// block only decides which requests are accepted, drives the RAM control pins
// and reports occupancy and status.
//
// Parameters:
//   mem_depth  number of RAM words (power of two, >= 4)
//   af_margin  almost_full  when usedw >= mem_depth - af_margin
//   ae_margin  almost_empty when usedw <= ae_margin
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   clear         synchronous flush, priority over push/pop
//   push / pop    producer write request / consumer read request
//   wren          RAM write enable
//   wraddress     RAM write address
//   rden          RAM read enable
//   rdaddress     RAM read address
//   rd_valid      RAM data_out holds the word popped on the previous cycle
//   full / empty  occupancy at the extremes (decoded from the state register)
//   almost_full   occupancy at or above the high watermark
//   almost_empty  occupancy at or below the low watermark
//   usedw         current occupancy, 0..mem_depth
//   overflow      sticky: a push was rejected
//   underflow     sticky: a pop was rejected
// -----------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int unsigned mem_depth = 32,
    parameter int unsigned af_margin = 2,
    parameter int unsigned ae_margin = 2,
    localparam int unsigned addr_w   = $clog2(mem_depth),
    localparam int unsigned cnt_w    = addr_w + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    output logic              wren,
    output logic [addr_w-1:0] wraddress,
    output logic              rden,
    output logic [addr_w-1:0] rdaddress,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [cnt_w-1:0]  usedw,
    output logic              overflow,
    output logic              underflow
);

    // State encoding kept as plain constants for compatibility with older
    // tools and netlist viewers.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_MID   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    // Occupancy thresholds, pre-sized to the counter width so every compare
    // below is width-exact.
    localparam logic [cnt_w-1:0] cnt_one      = cnt_w'(1);
    localparam logic [cnt_w-1:0] cnt_depth_m1 = cnt_w'(mem_depth - 1);
    localparam logic [cnt_w-1:0] af_level     = cnt_w'(mem_depth - af_margin);
    localparam logic [cnt_w-1:0] ae_level     = cnt_w'(ae_margin);

    logic [addr_w-1:0] wr_ptr;
    logic [addr_w-1:0] rd_ptr;
    logic [cnt_w-1:0]  used_q;
    logic [1:0]        state;
    logic [1:0]        state_next;

    logic push_ok;
    logic pop_ok;

    // -------------------------------------------------------------------------
    // Acceptance
    // -------------------------------------------------------------------------
    assign full  = (state == S_FULL);
    assign empty = (state == S_EMPTY);

    // When full, a push is still accepted if a pop frees a slot in the same
    // cycle: read and write then hit the same address and the RAM returns the
    // old word, which is exactly the word being popped. When empty, a pop is
    // never accepted, so push+pop degenerates into a plain push.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    // -------------------------------------------------------------------------
    // RAM drive
    // -------------------------------------------------------------------------
    // The enables are also gated by reset_n so that a producer still holding
    // push while reset is asserted cannot write into the RAM.
    assign wren      = push_ok & ~clear & reset_n;
    assign rden      = pop_ok & ~clear & reset_n;
    assign wraddress = wr_ptr;
    assign rdaddress = rd_ptr;

    // -------------------------------------------------------------------------
    // Status
    // -------------------------------------------------------------------------
    assign usedw        = used_q;
    assign almost_full  = (used_q >= af_level);
    assign almost_empty = (used_q <= ae_level);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // state_next unassigned and no latch is inferred.
        state_next = state;
        case (state)
            S_EMPTY: begin
                if (push_ok) begin
                    state_next = S_MID;
                end
            end
            S_MID: begin
                if (push_ok && !pop_ok && used_q == cnt_depth_m1) begin
                    state_next = S_FULL;
                end else if (pop_ok && !push_ok && used_q == cnt_one) begin
                    state_next = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop_ok && !push_ok) begin
                    state_next = S_MID;
                end
            end
            default: begin
                // Unreachable encoding: recover to a known-safe state.
                state_next = S_EMPTY;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: non-blocking assignments for all state, so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            used_q    <= '0;
            state     <= S_EMPTY;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            // Flush wins over any request in the same cycle and raises no
            // error flag.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            used_q    <= '0;
            state     <= S_EMPTY;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Pointers are exactly addr_w bits wide, so they wrap modulo
            // mem_depth without extra logic.
            if (push_ok) begin
                wr_ptr <= wr_ptr + addr_w'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + addr_w'(1);
            end

            case ({push_ok, pop_ok})
                2'b10:   used_q <= used_q + cnt_w'(1);
                2'b01:   used_q <= used_q - cnt_w'(1);
                default: used_q <= used_q;
            endcase

            state <= state_next;

            // The RAM registers its output on the same edge that consumes
            // rden, so the word is present for exactly the following cycle.
            rd_valid <= pop_ok;

            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Pointer, flag and handshake controller for a synchronous FIFO built around the team's dual-port RAM (registered read, one-cycle read latency, write-before-read not guaranteed). It accepts push/pop requests from the producer and consumer, drives the RAM's write/read enables and addresses, and reports occupancy and status flags. It sits directly upstream of the RAM's control pins. The data path (data_in/data_out) runs straight to the RAM and does not pass through this block.

Parameters:
mem_depth, 32, number of RAM words; must be a power of two, >= 4
af_margin, 2, almost_full asserts when usedw >= mem_depth - af_margin
ae_margin, 2, almost_empty asserts when usedw <= ae_margin

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush; has priority over push and pop
push  input  1  producer write request
pop  input  1  consumer read request
wren  output  1  RAM write enable
wraddress  output  AW  RAM write address, AW = $clog2(mem_depth)
rden  output  1  RAM read enable
rdaddress  output  AW  RAM read address
rd_valid  output  1  RAM data_out holds popped word this cycle
full  output  1  usedw == mem_depth
empty  output  1  usedw == 0
almost_full  output  1  see af_margin
almost_empty  output  1  see ae_margin
usedw  output  AW+1  current occupancy, 0..mem_depth
overflow  output  1  sticky: push rejected
underflow  output  1  sticky: pop rejected

Behaviour:
- Reset (reset_n low, asynchronous): wr_ptr=0, rd_ptr=0, usedw=0, state=S_EMPTY, rd_valid=0, overflow=0, underflow=0. Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0, wren=0, rden=0. Reset asserted mid-operation aborts everything immediately. The RAM contents are not touched.
- State machine: S_EMPTY, S_MID, S_FULL, registered and consistent with usedw. empty = (state==S_EMPTY). full = (state==S_FULL).
- Acceptance (combinational):
  - push_ok = push & (!full | pop)
  - pop_ok = pop & !empty
  - In S_FULL, a simultaneous push+pop is legal. The write and read target the same address, and the RAM returns the old word.
  - In S_EMPTY, a simultaneous push+pop accepts only the push.
- RAM drive (combinational from registers and inputs): wren = push_ok & !clear; wraddress = wr_ptr; rden = pop_ok & !clear; rdaddress = rd_ptr.
- Edge update when clear=0:
  - wr_ptr += push_ok; rd_ptr += pop_ok. Pointers wrap naturally modulo mem_depth.
  - usedw += push_ok - pop_ok.
  - rd_valid <= pop_ok. Data is valid exactly 1 cycle after rden.
- State transitions:
  - S_EMPTY -> S_MID on push_ok. If mem_depth == 1 it would go to full instead, but that configuration is excluded by the parameter rule.
  - S_MID -> S_FULL when push_ok & !pop_ok & usedw == mem_depth-1.
  - S_MID -> S_EMPTY when pop_ok & !push_ok & usedw == 1.
  - S_FULL -> S_MID on pop_ok & !push_ok.
  - Otherwise the state holds. Push+pop together never changes the state or usedw.
- Sticky error flags:
  - overflow <= 1 when push & !push_ok.
  - underflow <= 1 when pop & !pop_ok.
  - Both are cleared only by reset or clear.
- clear=1 at an edge: pointers, usedw and flags go to 0, state goes to S_EMPTY, rd_valid goes to 0. Push/pop in that cycle are ignored, wren/rden are forced low, and no error flags are set.
- almost_full and almost_empty are combinational from the registered usedw.

Test Plan:
- Reset, then 32 consecutive pushes -> wraddress steps 0..31. full=1 and usedw=32 after the 32nd edge; almost_full first asserts at usedw=30; empty is never set.
- From full, push without pop -> wren=0, usedw stays 32, overflow=1 and stays 1 until clear.
- From full, push+pop in the same cycle -> wren=1 and rden=1 at address 0, usedw stays 32, full stays 1, rd_valid=1 next cycle. The bench checks that data_out equals the originally written word 0.
- From empty, pop -> rden=0, underflow=1, rd_valid stays 0. From empty, push+pop -> only the write occurs, usedw=1, empty=0.
- Wrap-around: push 40 and pop 40 interleaved (3 pushes then 2 pops) -> addresses wrap 31->0, usedw never exceeds 32, and the popped sequence matches the pushed sequence in order.
- Mid-stream: assert clear with usedw=5 -> next cycle usedw=0, empty=1, flags=0. Then pulse reset_n low asynchronously mid-cycle while pushing -> outputs return to reset values immediately, before the next clock edge.
